// File: rtl/alu_pkg.sv
// Shared ALU opcode type, RV32I field constants and the ID/EX register layout.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRA = 4'b0111
  } alu_op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        valid;
    alu_op_t     alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic [31:0] branch_target;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  // alt selects SUB/SRA; callers only raise it where funct7 is meaningful.
  function automatic alu_op_t funct3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B/U/shamt immediate implied by the opcode.
import alu_pkg::*;

module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Immediate select; shift-immediates carry a zero-extended shamt instead of the I-immediate.
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_I: begin
        if (funct3 == F3_SLL || funct3 == F3_SR) imm = {27'b0, instr[24:20]};
        else                                     imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD:   imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI:    imm = {instr[31:12], 12'b0};
      default:    imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// RV32I decode for the EX-stage ALU plus the ID/EX pipeline register.
import alu_pkg::*;

module id_ex_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        stall,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_control,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_branch_ne,
  output logic [31:0] ex_branch_target,
  output logic        ex_illegal,
  output logic [15:0] illegal_count
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm;
  logic        legal;
  logic        writes_rd;
  id_ex_t      dec;
  id_ex_t      ex_q;
  logic        illegal_q;
  logic [15:0] count_q;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_field = instr[11:7];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  // Instruction decode: legality check and the full ID/EX payload for a legal instruction.
  always_comb begin
    dec       = ID_EX_BUBBLE;
    legal     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_R: begin
        legal = (funct7 == F7_BASE && funct3 != F3_SLT && funct3 != F3_SLTU) ||
                (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
        dec.alu_control = funct3_to_alu(funct3, funct7[5]);
        dec.op_a        = rs1_data;
        dec.op_b        = rs2_data;
        writes_rd       = 1'b1;
      end
      OPC_I: begin
        case (funct3)
          F3_ADD, F3_XOR, F3_OR, F3_AND: legal = 1'b1;
          F3_SLL: legal = (funct7 == F7_BASE);
          F3_SR:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b0;
        endcase
        // Only the right-shift form reads funct7; for ADDI those bits are immediate.
        dec.alu_control = funct3_to_alu(funct3, (funct3 == F3_SR) && funct7[5]);
        dec.op_a        = rs1_data;
        dec.op_b        = imm;
        writes_rd       = 1'b1;
      end
      OPC_LOAD: begin
        legal           = 1'b1;
        dec.alu_control = ALU_ADD;
        dec.op_a        = rs1_data;
        dec.op_b        = imm;
        dec.mem_read    = 1'b1;
        writes_rd       = 1'b1;
      end
      OPC_STORE: begin
        legal           = 1'b1;
        dec.alu_control = ALU_ADD;
        dec.op_a        = rs1_data;
        dec.op_b        = imm;
        dec.store_data  = rs2_data;
        dec.mem_write   = 1'b1;
      end
      OPC_BRANCH: begin
        legal             = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        dec.alu_control   = ALU_SUB;
        dec.op_a          = rs1_data;
        dec.op_b          = rs2_data;
        dec.branch        = (funct3 == F3_BEQ);
        dec.branch_ne     = (funct3 == F3_BNE);
        dec.branch_target = pc + imm;
      end
      OPC_LUI: begin
        legal           = 1'b1;
        dec.alu_control = ALU_ADD;
        dec.op_a        = '0;
        dec.op_b        = imm;
        writes_rd       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.valid     = 1'b1;
    dec.rd        = writes_rd ? rd_field : 5'd0;
    dec.reg_write = writes_rd && (rd_field != 5'd0);
  end

  // ID/EX register and illegal counter; priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= ID_EX_BUBBLE;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (flush) begin
      ex_q      <= ID_EX_BUBBLE;
      illegal_q <= 1'b0;
    end else if (stall) begin
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= (id_valid && legal) ? dec : ID_EX_BUBBLE;
      illegal_q <= id_valid && !legal;
      if (id_valid && !legal && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign id_ready         = !stall;
  assign ex_valid         = ex_q.valid;
  assign ex_alu_control   = ex_q.alu_control;
  assign ex_op_a          = ex_q.op_a;
  assign ex_op_b          = ex_q.op_b;
  assign ex_store_data    = ex_q.store_data;
  assign ex_rd            = ex_q.rd;
  assign ex_reg_write     = ex_q.reg_write;
  assign ex_mem_read      = ex_q.mem_read;
  assign ex_mem_write     = ex_q.mem_write;
  assign ex_branch        = ex_q.branch;
  assign ex_branch_ne     = ex_q.branch_ne;
  assign ex_branch_target = ex_q.branch_target;
  assign ex_illegal       = illegal_q;
  assign illegal_count    = count_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: mnemonic-level reference model checked every cycle, plus literal spot checks.
module tb_id_ex_decode;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_branch_ne, ex_illegal;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_op_a, ex_op_b, ex_store_data, ex_branch_target;
  logic [4:0]  ex_rd;
  logic [15:0] illegal_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_decode dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
    .ex_branch_target(ex_branch_target), .ex_illegal(ex_illegal),
    .illegal_count(illegal_count)
  );

  typedef struct {
    bit          valid;
    bit [3:0]    alu;
    bit [31:0]   a, b, sd, tgt;
    bit [4:0]    rd;
    bit          rw, mr, mw, br, bne;
  } exp_t;

  // Reference decode written per mnemonic.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 output bit ok);
    exp_t e;
    bit [6:0] opc = i[6:0];
    bit [2:0] f3  = i[14:12];
    bit [6:0] f7  = i[31:25];
    bit       wr  = 0;
    e  = '{default: 0};
    ok = 0;
    if (opc == 7'h33) begin
      e.a = r1; e.b = r2; wr = 1;
      if (f7 == 7'h00) begin
        ok = 1;
        case (f3)
          3'd0: e.alu = 4'd2;  3'd1: e.alu = 4'd4;  3'd4: e.alu = 4'd3;
          3'd5: e.alu = 4'd5;  3'd6: e.alu = 4'd1;  3'd7: e.alu = 4'd0;
          default: ok = 0;
        endcase
      end else if (f7 == 7'h20) begin
        if (f3 == 3'd0) begin ok = 1; e.alu = 4'd6; end
        if (f3 == 3'd5) begin ok = 1; e.alu = 4'd7; end
      end
    end else if (opc == 7'h13) begin
      e.a = r1; wr = 1;
      e.b = {{20{i[31]}}, i[31:20]};
      case (f3)
        3'd0: begin ok = 1; e.alu = 4'd2; end
        3'd4: begin ok = 1; e.alu = 4'd3; end
        3'd6: begin ok = 1; e.alu = 4'd1; end
        3'd7: begin ok = 1; e.alu = 4'd0; end
        3'd1: begin ok = (f7 == 7'h00); e.alu = 4'd4; e.b = {27'd0, i[24:20]}; end
        3'd5: begin
          ok = (f7 == 7'h00) || (f7 == 7'h20);
          e.alu = (f7 == 7'h20) ? 4'd7 : 4'd5; e.b = {27'd0, i[24:20]};
        end
        default: ok = 0;
      endcase
    end else if (opc == 7'h03) begin
      ok = 1; wr = 1; e.alu = 4'd2; e.a = r1; e.b = {{20{i[31]}}, i[31:20]}; e.mr = 1;
    end else if (opc == 7'h23) begin
      ok = 1; e.alu = 4'd2; e.a = r1; e.b = {{20{i[31]}}, i[31:25], i[11:7]};
      e.mw = 1; e.sd = r2;
    end else if (opc == 7'h63) begin
      ok = (f3 == 3'd0) || (f3 == 3'd1);
      e.alu = 4'd6; e.a = r1; e.b = r2; e.br = (f3 == 3'd0); e.bne = (f3 == 3'd1);
      e.tgt = p + {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    end else if (opc == 7'h37) begin
      ok = 1; wr = 1; e.alu = 4'd2; e.a = 0; e.b = {i[31:12], 12'h000};
    end
    e.valid = 1;
    e.rd = wr ? i[11:7] : 5'd0;
    e.rw = wr && (i[11:7] != 0);
    if (!ok) e = '{default: 0};
    return e;
  endfunction

  exp_t m;
  bit   m_ill;
  int   m_cnt;
  bit   chk_en = 0;

  always @(posedge clk) begin
    exp_t d;
    bit ok;
    if (rst) begin
      m = '{default: 0}; m_ill = 0; m_cnt = 0;
    end else if (flush) begin
      m = '{default: 0}; m_ill = 0;
    end else if (stall) begin
      m_ill = 0;
    end else begin
      d = model(instr, pc, rs1_data, rs2_data, ok);
      m = (id_valid && ok) ? d : '{default: 0};
      m_ill = id_valid && !ok;
      if (id_valid && !ok && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid",  32'(ex_valid),         32'(m.valid));
      chk("m_alu",    32'(ex_alu_control),   32'(m.alu));
      chk("m_op_a",   ex_op_a,               m.a);
      chk("m_op_b",   ex_op_b,               m.b);
      chk("m_sdata",  ex_store_data,         m.sd);
      chk("m_rd",     32'(ex_rd),            32'(m.rd));
      chk("m_rw",     32'(ex_reg_write),     32'(m.rw));
      chk("m_mr",     32'(ex_mem_read),      32'(m.mr));
      chk("m_mw",     32'(ex_mem_write),     32'(m.mw));
      chk("m_br",     32'(ex_branch),        32'(m.br));
      chk("m_bne",    32'(ex_branch_ne),     32'(m.bne));
      chk("m_tgt",    ex_branch_target,      m.tgt);
      chk("m_ill",    32'(ex_illegal),       32'(m_ill));
      chk("m_cnt",    32'(illegal_count),    32'(m_cnt));
      chk("m_ready",  32'(id_ready),         32'(!stall));
    end
  end

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic f, input logic r);
    id_valid = v; instr = i; pc = p; rs1_data = a; rs2_data = b;
    stall = s; flush = f; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] i, input logic [31:0] p,
                    input logic [31:0] a, input logic [31:0] b);
    step(1'b1, i, p, a, b, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_LUI  = 32'h123453B7;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;

  logic [31:0] misc [8] = '{
    32'h00108013,  // ADDI x0,x1,1 : reg_write suppressed
    32'h0040A303,  // LW x6,4(x1)
    32'h00209463,  // BNE x1,x2,+8
    32'h0020C1B3,  // XOR
    32'h0020F1B3,  // AND
    32'h00000017,  // AUIPC : illegal
    32'h0000006F,  // JAL : illegal
    32'h40209193   // SLLI with funct7=0100000 : illegal
  };

  initial begin
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_en = 1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);

    go(I_ADD, 32'h0, 32'd5, 32'd7);
    chk("add_alu",   32'(ex_alu_control), 32'h2);
    chk("add_a",     ex_op_a, 32'd5);
    chk("add_b",     ex_op_b, 32'd7);
    chk("add_rd",    32'(ex_rd), 32'd3);
    chk("add_rw",    32'(ex_reg_write), 32'd1);
    chk("add_valid", 32'(ex_valid), 32'd1);

    go(I_SUB, 32'h0, 32'd9, 32'd4);
    chk("sub_alu", 32'(ex_alu_control), 32'h6);
    go(I_SRAI, 32'h0, 32'h8000_0000, 32'd1);
    chk("srai_alu", 32'(ex_alu_control), 32'h7);
    chk("srai_b",   ex_op_b, 32'd3);
    go(I_ADDI, 32'h0, 32'h55, 32'd1);
    chk("addi_b", ex_op_b, 32'hFFFF_FFFF);
    chk("addi_a", ex_op_a, 32'h55);

    go(I_BEQ, 32'h100, 32'd1, 32'd2);
    chk("beq_alu", 32'(ex_alu_control), 32'h6);
    chk("beq_br",  32'(ex_branch), 32'd1);
    chk("beq_bne", 32'(ex_branch_ne), 32'd0);
    chk("beq_tgt", ex_branch_target, 32'h108);
    chk("beq_rw",  32'(ex_reg_write), 32'd0);

    go(I_SW, 32'h0, 32'h1000, 32'h77);
    chk("sw_alu", 32'(ex_alu_control), 32'h2);
    chk("sw_b",   ex_op_b, 32'd4);
    chk("sw_mw",  32'(ex_mem_write), 32'd1);
    chk("sw_sd",  ex_store_data, 32'h77);
    go(I_LUI, 32'h0, 32'h99, 32'h0);
    chk("lui_a", ex_op_a, 32'h0);
    chk("lui_b", ex_op_b, 32'h12345000);

    for (int k = 0; k < 8; k++) go(misc[k], 32'h200 + 32'(4 * k), 32'h10 + 32'(k), 32'h20);
    step(1'b0, I_SLT, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("novalid_ill", 32'(ex_illegal), 32'd0);

    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    go(I_SLT, 32'h0, 32'd1, 32'd2);
    chk("slt_valid", 32'(ex_valid), 32'd0);
    chk("slt_ill",   32'(ex_illegal), 32'd1);
    chk("slt_cnt",   32'(illegal_count), 32'd1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("slt_pulse", 32'(ex_illegal), 32'd0);

    for (int k = 0; k < 65534; k++) go(I_SLT, 32'h0, 32'd1, 32'd2);
    chk("sat_reach", 32'(illegal_count), 32'hFFFF);
    go(I_SLT, 32'h0, 32'd1, 32'd2);
    chk("sat_hold", 32'(illegal_count), 32'hFFFF);

    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    go(I_ADD, 32'h0, 32'd5, 32'd7);
    step(1'b1, I_SLT, 32'h0, 32'd11, 32'd12, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_SUB, 32'h0, 32'd13, 32'd14, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_LUI, 32'h0, 32'd15, 32'd16, 1'b1, 1'b0, 1'b0);
    chk("stall_a",   ex_op_a, 32'd5);
    chk("stall_alu", 32'(ex_alu_control), 32'h2);
    chk("stall_cnt", 32'(illegal_count), 32'd0);
    chk("stall_rdy", 32'(id_ready), 32'd0);

    step(1'b1, I_SUB, 32'h0, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    chk("sflush_valid", 32'(ex_valid), 32'd0);
    go(I_ADD, 32'h0, 32'd5, 32'd7);
    step(1'b1, I_SLT, 32'h0, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
    chk("flush_ill", 32'(ex_illegal), 32'd0);
    chk("flush_cnt", 32'(illegal_count), 32'd0);

    go(I_BEQ, 32'h100, 32'd1, 32'd2);
    step(1'b1, I_ADD, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
    chk("rst_stall_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall_tgt",   ex_branch_target, 32'd0);
    chk("rst_stall_br",    32'(ex_branch), 32'd0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_decode.md
# id_ex_decode

Decode-and-register stage feeding the EX-stage ALU. It translates an RV32I instruction into the 4-bit ALU operation code and the two ready-to-use ALU operands, plus memory, branch and writeback controls. It holds the result in the ID/EX pipeline register with stall/flush handling. It sits between the IF/ID register and register-file read on one side and the ALU on the other.

## Interface
- No parameters; widths fixed at XLEN=32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  instr/pc valid from IF/ID
- instr  in  32  instruction word
- pc  in  32  instruction address
- rs1_data, rs2_data  in  32 each  register-file read data
- stall  in  1  hold ID/EX contents
- flush  in  1  replace ID/EX contents with bubble
- id_ready  out  1  combinational, = !stall
- ex_valid  out  1  ID/EX holds a real instruction
- ex_alu_control  out  4  ALU op: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111
- ex_op_a, ex_op_b  out  32 each  ALU operands
- ex_store_data  out  32  rs2_data for stores
- ex_rd  out  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_branch, ex_branch_ne  out  1 each  BEQ / BNE qualifier on ALU zeroflag
- ex_branch_target  out  32  pc + B-immediate
- ex_illegal  out  1  one-cycle pulse: rejected instruction
- illegal_count  out  16  saturating count of rejected instructions

## Operation
- Decode is combinational from instr; all ex_* outputs are registered.
- Supported opcodes and mappings:
  - R-type 0110011: funct7 0000000 with any funct3 except 010/011; funct7 0100000 only with funct3 000 (SUB) or 101 (SRA). op_a=rs1, op_b=rs2.
  - I-type 0010011: ADDI/XORI/ORI/ANDI use the sign-extended instr[31:20]. SLLI needs funct7=0; SRLI/SRAI need funct7 0000000/0100000. Shifts use op_b = zero-extended instr[24:20].
  - LOAD 0000011: ADD, op_b = I-immediate, mem_read=1.
  - STORE 0100011: ADD, op_b = S-immediate, mem_write=1, reg_write=0.
  - BRANCH 1100011: funct3 000 or 001 only. SUB, op_a=rs1, op_b=rs2, target = pc + sign-extended B-immediate (bit0=0).
  - LUI 0110111: ADD, op_a=0, op_b={instr[31:12],12'b0}.
- Anything else is illegal, including SLT/SLTU/SLTI/SLTIU, AUIPC, JAL, JALR, SYSTEM and FENCE.
- reg_write is forced 0 when rd=0.
- An illegal instruction with id_valid=1 loads a bubble (ex_valid=0, all controls 0) and sets ex_illegal=1 for that cycle. illegal_count increments and saturates at 0xFFFF.
- id_valid=0 loads a bubble with ex_illegal=0.

## Timing
- Register update priority: rst > flush > stall > load.
- rst: every ex_* output, ex_illegal and illegal_count go to 0.
- flush: bubble next cycle, even when stall=1. ex_illegal=0 and the count is unchanged, even if the instruction was illegal.
- stall without flush: all ex_* held and ex_illegal=0. The ID instruction is not counted; it will be re-presented.
- Latency is 1 cycle: an instruction presented at edge N appears on ex_* after edge N.
- Reset mid-stall discards held contents. No state survives reset.

## Structure
- Package alu_pkg holds:
  - typedef alu_op_t (4-bit enum) with the eight codes above, shared with the ALU;
  - opcode, funct3 and funct7 localparams;
  - typedef id_ex_t, a packed struct of all ex_* fields.
- One sub-module, imm_gen: combinational I/S/B/U/shamt immediate generation selected by opcode.
- Decode lives in one always_comb block. The ID/EX register and illegal_count live in one always_ff block.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle: ex_alu_control=0010, op_a=5, op_b=7, rd=3, reg_write=1, ex_valid=1.
- SUB 0x402081B3 -> 0110. SRAI x5,x6,3 (0x40335293) -> 0111, op_b=3. ADDI x1,x0,-1 (0xFFF00093) -> op_b=0xFFFFFFFF, op_a=rs1_data.
- BEQ x1,x2,+8 (0x00208463) at pc=0x100 -> 0110, branch=1, branch_ne=0, target=0x108, reg_write=0.
- SW x2,4(x1) (0x0020A223) -> 0010, op_b=4, mem_write=1, store_data=rs2_data. LUI x7,0x12345 (0x123453B7) -> op_a=0, op_b=0x12345000.
- SLT (0x0020A1B3) -> ex_valid=0, ex_illegal=1 for one cycle, illegal_count 0->1. Force the count to 0xFFFF and apply another illegal -> stays 0xFFFF.
- Stall 3 cycles with a changing instr -> ex_* frozen. Assert stall and flush together -> bubble. Assert rst during stall -> all outputs 0 next edge.
